// File: rtl/irq_timer_controller.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp timer, software IRQ bit and
// synchronised external IRQ (level or edge), with a small word-addressed register port.
module irq_timer_controller #(
   parameter int unsigned EXT_SYNC_STAGES = 2,
   parameter int unsigned PRESCALE        = 1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        IRQ_IN,
   input  logic [2:0]  REG_ADDR,
   input  logic [31:0] REG_WDATA,
   input  logic        REG_WE,
   input  logic        REG_RE,
   output logic [31:0] REG_RDATA,
   output logic        E_IRQ,
   output logic        T_IRQ,
   output logic        S_IRQ
);

   localparam int unsigned PS_W = $clog2(PRESCALE) + 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   typedef enum logic [2:0] {
      A_MTIME_LO    = 3'd0,
      A_MTIME_HI    = 3'd1,
      A_MTIMECMP_LO = 3'd2,
      A_MTIMECMP_HI = 3'd3,
      A_MSIP        = 3'd4,
      A_EXT_CTRL    = 3'd5
   } reg_addr_e;

   logic [63:0]                mtime_q, mtime_d;
   logic [63:0]                mtimecmp_q, mtimecmp_d;
   logic [PS_W-1:0]            ps_cnt_q, ps_cnt_d;
   logic                       msip_q, msip_d;
   logic                       ext_mode_q, ext_mode_d;
   logic                       ext_pending_q, ext_pending_d;
   logic [EXT_SYNC_STAGES-1:0] sync_q, sync_d;
   logic                       sync_dly_q, sync_dly_d;
   logic                       e_irq_q, e_irq_d;
   logic                       t_irq_q, t_irq_d;
   logic                       s_irq_q, s_irq_d;
   logic [31:0]                rdata_q, rdata_d;
   logic                       tick;
   logic                       sync;

   assign sync = sync_q[EXT_SYNC_STAGES-1];
   assign tick = (ps_cnt_q == PS_MAX);

   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      ps_cnt_d      = tick ? '0 : ps_cnt_q + PS_W'(1);
      mtime_d       = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d    = mtimecmp_q;
      msip_d        = msip_q;
      ext_mode_d    = ext_mode_q;
      ext_pending_d = ext_pending_q;
      sync_d        = {sync_q[EXT_SYNC_STAGES-2:0], IRQ_IN};
      sync_dly_d    = sync;
      rdata_d       = rdata_q;

      // A write to either mtime half suppresses that cycle's increment entirely.
      if (REG_WE) begin
         case (REG_ADDR)
            A_MTIME_LO:    mtime_d    = {mtime_q[63:32], REG_WDATA};
            A_MTIME_HI:    mtime_d    = {REG_WDATA, mtime_q[31:0]};
            A_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], REG_WDATA};
            A_MTIMECMP_HI: mtimecmp_d = {REG_WDATA, mtimecmp_q[31:0]};
            A_MSIP:        msip_d     = REG_WDATA[0];
            A_EXT_CTRL: begin
               ext_mode_d = REG_WDATA[0];
               if (REG_WDATA[1]) ext_pending_d = 1'b0;
            end
            default: ;
         endcase
      end

      // Edge detection overrides a same-cycle W1C so no edge is ever lost.
      if (ext_mode_q && sync && !sync_dly_q) ext_pending_d = 1'b1;

      if (REG_RE) begin
         case (REG_ADDR)
            A_MTIME_LO:    rdata_d = mtime_q[31:0];
            A_MTIME_HI:    rdata_d = mtime_q[63:32];
            A_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
            A_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
            A_MSIP:        rdata_d = {31'd0, msip_q};
            A_EXT_CTRL:    rdata_d = {30'd0, ext_pending_q, ext_mode_q};
            default:       rdata_d = '0;
         endcase
      end

      e_irq_d = ext_mode_q ? ext_pending_q : sync;
      t_irq_d = (mtime_q >= mtimecmp_q);
      s_irq_d = msip_q;
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mtime_q       <= '0;
         mtimecmp_q    <= '1;
         ps_cnt_q      <= '0;
         msip_q        <= 1'b0;
         ext_mode_q    <= 1'b0;
         ext_pending_q <= 1'b0;
         sync_q        <= '0;
         sync_dly_q    <= 1'b0;
         e_irq_q       <= 1'b0;
         t_irq_q       <= 1'b0;
         s_irq_q       <= 1'b0;
         rdata_q       <= '0;
      end else begin
         mtime_q       <= mtime_d;
         mtimecmp_q    <= mtimecmp_d;
         ps_cnt_q      <= ps_cnt_d;
         msip_q        <= msip_d;
         ext_mode_q    <= ext_mode_d;
         ext_pending_q <= ext_pending_d;
         sync_q        <= sync_d;
         sync_dly_q    <= sync_dly_d;
         e_irq_q       <= e_irq_d;
         t_irq_q       <= t_irq_d;
         s_irq_q       <= s_irq_d;
         rdata_q       <= rdata_d;
      end
   end

   assign REG_RDATA = rdata_q;
   assign E_IRQ     = e_irq_q;
   assign T_IRQ     = t_irq_q;
   assign S_IRQ     = s_irq_q;

endmodule

// File: tb/tb_irq_timer_controller.sv
// Scoreboard bench for irq_timer_controller: two instances (PRESCALE 1 and 4) share one
// stimulus stream; a behavioural model predicts outputs per cycle, a monitor compares them.
module tb_irq_timer_controller;

   localparam int N   = 2;
   localparam int PS0 = 1;
   localparam int PS1 = 4;

   typedef struct {
      bit          e_irq;
      bit          t_irq;
      bit          s_irq;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        irq_in;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic [1:0][31:0] rdata;
   logic [1:0]  e_irq;
   logic [1:0]  t_irq;
   logic [1:0]  s_irq;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [63:0] m_mtime [2];
   logic [63:0] m_cmp   [2];
   int          m_pcnt  [2];
   bit          m_msip  [2];
   bit          m_mode  [2];
   bit          m_pend  [2];
   logic [31:0] m_rdata [2];
   bit          hist    [0:7];
   exp_t        exp_q0[$];
   exp_t        exp_q1[$];

   irq_timer_controller #(.EXT_SYNC_STAGES(N), .PRESCALE(PS0)) u_dut0 (
      .CLK(clk), .RESET_N(rst_n), .IRQ_IN(irq_in),
      .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata), .REG_WE(reg_we), .REG_RE(reg_re),
      .REG_RDATA(rdata[0]), .E_IRQ(e_irq[0]), .T_IRQ(t_irq[0]), .S_IRQ(s_irq[0])
   );

   irq_timer_controller #(.EXT_SYNC_STAGES(N), .PRESCALE(PS1)) u_dut1 (
      .CLK(clk), .RESET_N(rst_n), .IRQ_IN(irq_in),
      .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata), .REG_WE(reg_we), .REG_RE(reg_re),
      .REG_RDATA(rdata[1]), .E_IRQ(e_irq[1]), .T_IRQ(t_irq[1]), .S_IRQ(s_irq[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int inst, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d at %0t: actual=%0h expected=%0h", name, inst, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mtime[i] = 64'd0;
         m_cmp[i]   = {64{1'b1}};
         m_pcnt[i]  = 0;
         m_msip[i]  = 1'b0;
         m_mode[i]  = 1'b0;
         m_pend[i]  = 1'b0;
         m_rdata[i] = 32'd0;
      end
      for (int k = 0; k < 8; k++) hist[k] = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
   endtask

   function automatic logic [31:0] model_read(input int i, input logic [2:0] a);
      case (a)
         3'd0:    return m_mtime[i][31:0];
         3'd1:    return m_mtime[i][63:32];
         3'd2:    return m_cmp[i][31:0];
         3'd3:    return m_cmp[i][63:32];
         3'd4:    return {31'd0, m_msip[i]};
         3'd5:    return {30'd0, m_pend[i], m_mode[i]};
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the architectural behaviour, using pre-edge values throughout.
   // hist[k] holds IRQ_IN as sampled k+1 edges before the current one.
   task automatic model_step();
      bit sync_pre     = hist[N-1];
      bit sync_dly_pre = hist[N];
      for (int i = 0; i < 2; i++) begin
         exp_t        e;
         bit          tick;
         bit          set_pend;
         int          ps;
         logic [63:0] mt;
         ps        = (i == 0) ? PS0 : PS1;
         e.e_irq   = m_mode[i] ? m_pend[i] : sync_pre;
         e.t_irq   = (m_mtime[i] >= m_cmp[i]);
         e.s_irq   = m_msip[i];
         if (reg_re) m_rdata[i] = model_read(i, reg_addr);
         e.rdata   = m_rdata[i];
         set_pend  = m_mode[i] && sync_pre && !sync_dly_pre;
         tick      = (m_pcnt[i] == ps - 1);
         m_pcnt[i] = tick ? 0 : m_pcnt[i] + 1;
         mt        = tick ? m_mtime[i] + 64'd1 : m_mtime[i];
         if (reg_we) begin
            case (reg_addr)
               3'd0: mt = {m_mtime[i][63:32], reg_wdata};
               3'd1: mt = {reg_wdata, m_mtime[i][31:0]};
               3'd2: m_cmp[i] = {m_cmp[i][63:32], reg_wdata};
               3'd3: m_cmp[i] = {reg_wdata, m_cmp[i][31:0]};
               3'd4: m_msip[i] = reg_wdata[0];
               3'd5: begin
                  m_mode[i] = reg_wdata[0];
                  if (reg_wdata[1]) m_pend[i] = 1'b0;
               end
               default: ;
            endcase
         end
         if (set_pend) m_pend[i] = 1'b1;
         m_mtime[i] = mt;
         if (i == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
      end
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_in;
   endtask

   always @(posedge clk) if (rst_n) model_step();
   always @(negedge rst_n) model_reset();

   task automatic compare_outputs(input int i, input exp_t ex);
      check("e_irq", i, 64'(e_irq[i]), 64'(ex.e_irq));
      check("t_irq", i, 64'(t_irq[i]), 64'(ex.t_irq));
      check("s_irq", i, 64'(s_irq[i]), 64'(ex.s_irq));
      check("reg_rdata", i, 64'(rdata[i]), 64'(ex.rdata));
   endtask

   // Monitor: outputs are sampled on the falling edge, half a cycle after they update.
   always @(negedge clk) begin
      exp_t ex;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            check("reset_e_irq", i, 64'(e_irq[i]), 64'd0);
            check("reset_t_irq", i, 64'(t_irq[i]), 64'd0);
            check("reset_s_irq", i, 64'(s_irq[i]), 64'd0);
            check("reset_rdata", i, 64'(rdata[i]), 64'd0);
         end
      end else begin
         if (exp_q0.size() > 0) begin
            ex = exp_q0.pop_front();
            compare_outputs(0, ex);
         end
         if (exp_q1.size() > 0) begin
            ex = exp_q1.pop_front();
            compare_outputs(1, ex);
         end
      end
   end

   task automatic bus(input bit we, input bit re, input logic [2:0] a, input logic [31:0] d);
      reg_we    = we;
      reg_re    = re;
      reg_addr  = a;
      reg_wdata = d;
      @(posedge clk);
      #1;
      reg_we = 1'b0;
      reg_re = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus(1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [2:0] a);
      bus(1'b0, 1'b1, a, 32'd0);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) bus(1'b0, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      rst_n     = 1'b0;
      irq_in    = 1'b0;
      reg_addr  = 3'd0;
      reg_wdata = 32'd0;
      reg_we    = 1'b0;
      reg_re    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset/idle: mtime free-runs from 0
      idle(10);
      rd(3'd0);
      rd(3'd2);
      rd(3'd3);

      // Timer fire at 20, then mtimecmp raised
      wr(3'd1, 32'd0);
      wr(3'd0, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd20);
      idle(25);
      wr(3'd2, 32'd1000);
      idle(4);

      // Wrap-around with mtimecmp at all ones
      wr(3'd3, 32'hFFFF_FFFF);
      wr(3'd2, 32'hFFFF_FFFF);
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd0, 32'hFFFF_FFFE);
      for (int c = 0; c < 14; c++) rd(3'd0);
      rd(3'd1);

      // Write/tick collision
      wr(3'd1, 32'd0);
      wr(3'd0, 32'd5);
      rd(3'd0);
      rd(3'd0);

      // Software interrupt
      wr(3'd4, 32'd1);
      rd(3'd4);
      wr(3'd4, 32'd0);
      rd(3'd4);
      idle(2);

      // Edge mode: single-cycle pulse, W1C, then an edge coinciding with W1C
      wr(3'd5, 32'd1);
      irq_in = 1'b1;
      idle(1);
      irq_in = 1'b0;
      idle(6);
      rd(3'd5);
      wr(3'd5, 32'd3);
      idle(4);
      irq_in = 1'b1;
      idle(2);
      wr(3'd5, 32'd3);
      irq_in = 1'b0;
      idle(3);
      rd(3'd5);

      // Level mode: pending survives the mode switch, E_IRQ follows the synchroniser
      wr(3'd5, 32'd0);
      rd(3'd5);
      for (int c = 0; c < 16; c++) begin
         irq_in = (c % 5) < 2;
         idle(1);
      end
      irq_in = 1'b0;
      idle(4);

      // Mid-operation reset
      pulse_reset();
      idle(3);
      rd(3'd0);
      rd(3'd5);

      // Randomised traffic
      for (int c = 0; c < 1500; c++) begin
         logic [2:0]  a;
         logic [31:0] d;
         bit          we;
         bit          re;
         if (c == 700) pulse_reset();
         if ($urandom_range(0, 3) == 0) irq_in = ~irq_in;
         a  = 3'($urandom_range(0, 7));
         we = ($urandom_range(0, 3) == 0);
         re = ($urandom_range(0, 1) == 0);
         case (a)
            3'd0, 3'd2: d = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 3000));
            3'd1, 3'd3: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            default:    d = $urandom;
         endcase
         bus(we, re, a, d);
      end

      irq_in = 1'b0;
      idle(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
